ysyx_22041412_ifu: RTL

YSYX_22041412_IFU -- requirements
Module: ysyx_22041412_ifu

---
 rtl/ysyx_22041412_ifu.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: one outstanding imem request feeding a QDEPTH-entry instruction queue.
// Optional macro YSYX_22041412_IFU_ALIGN_CHECK_EN adds a sticky misaligned-redirect flag that halts fetch.
module ysyx_22041412_ifu #(
   parameter logic [63:0] RESET_PC = 64'h0000000080000000,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [63:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   output logic [63:0] out_pc,
   output logic [31:0] out_inst,
   input  logic        out_ready
`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
   ,
   output logic        misalign_err
`endif
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

   logic [63:0]   r_pc;
   logic [63:0]   r_req_addr;
   logic          r_outstanding;
   logic          r_drop;
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [63:0]   r_q_pc   [QDEPTH];
   logic [31:0]   r_q_inst [QDEPTH];

   logic [63:0]   w_redirect_pc;
   logic          w_halt;
   logic          w_req_fire;
   logic          w_rsp_fire;
   logic          w_push;
   logic          w_pop;

`ifdef YSYX_22041412_IFU_ALIGN_CHECK_EN
   logic r_misalign;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_misalign <= 1'b0;
      end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
         r_misalign <= 1'b1;
      end
   end

   assign misalign_err  = r_misalign;
   assign w_redirect_pc = redirect_pc;
   assign w_halt        = r_misalign;
`else
   logic w_unused_low_bits;

   assign w_unused_low_bits = ^redirect_pc[1:0];
   assign w_redirect_pc     = {redirect_pc[63:2], 2'b00};
   assign w_halt            = 1'b0;
`endif

   // The slot for an outstanding response is reserved up front, so a response never finds the queue full.
   assign imem_req_valid = !rst && !r_outstanding && !r_drop && !redirect_valid && !w_halt &&
                           ((r_count + CW'(r_outstanding)) < DEPTH_C);
   assign imem_req_addr  = r_pc;

   assign w_req_fire = imem_req_valid && imem_req_ready;
   assign w_rsp_fire = imem_rsp_valid && r_outstanding;
   assign w_push     = w_rsp_fire && !r_drop && !redirect_valid;
   assign w_pop      = out_valid && out_ready && !redirect_valid;

   assign out_valid = (r_count != '0);
   assign out_pc    = out_valid ? r_q_pc[r_head]   : 64'd0;
   assign out_inst  = out_valid ? r_q_inst[r_head] : 32'd0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_req_addr    <= 64'd0;
         r_outstanding <= 1'b0;
         r_drop        <= 1'b0;
      end else begin
         if (redirect_valid) begin
            r_pc <= w_redirect_pc;
         end else if (w_req_fire) begin
            r_pc <= r_pc + 64'd4;
         end

         if (w_req_fire) begin
            r_req_addr <= r_pc;
         end

         if (w_req_fire) begin
            r_outstanding <= 1'b1;
         end else if (w_rsp_fire) begin
            r_outstanding <= 1'b0;
         end

         // A response still in flight at redirect belongs to the old path and must be swallowed.
         if (redirect_valid && r_outstanding && !w_rsp_fire) begin
            r_drop <= 1'b1;
         end else if (w_rsp_fire) begin
            r_drop <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_pc[r_tail]   <= r_req_addr;
         r_q_inst[r_tail] <= imem_rsp_data;
      end
   end

endmodule
